mul32_seq_core: RTL and testbench

Iterative radix-2 shift-add multiplier that computes a 64-bit product from two 32-bit operands. It sits directly downstream of the Wishbone register front-end inside `user_proj_mul32`. The front-end writes the operands and pulses `start_i`. It reads `result_o` back over Wishbone and routes `done_o` to `irq[0]`. The block uses one product adder and runs one iteration per clock, trading latency for area.

---
 rtl/mul32_seq_core.sv | 149 ++++++++++++++
 tb/tb_mul32_seq_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul32_seq_core.sv
// Iterative radix-2 shift-add multiplier: one add/shift per clock, 2*BITS-bit product.
// Define MUL32_SIGNED_EN to add the sgn_i port and a FIX state for two's-complement operands.
module mul32_seq_core #(
  parameter int BITS = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [BITS-1:0]   a_i,
  input  logic [BITS-1:0]   b_i,
  input  logic              start_i,
`ifdef MUL32_SIGNED_EN
  input  logic              sgn_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_o,
  output logic [2*BITS-1:0] result_o
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

`ifdef MUL32_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   mcand_q, mcand_d;
  logic [2*BITS:0]   p_q, p_d;
  logic [2*BITS-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
`ifdef MUL32_SIGNED_EN
  logic              neg_q, neg_d;
`endif

  logic [BITS-1:0]   a_mag, b_mag;
  logic [BITS:0]     sum;
  logic [2*BITS:0]   p_step;

  // P[2*BITS] is always 0 between iterations, so the upper slice doubles as the zero-extended addend.
  always_comb begin
    sum    = p_q[2*BITS:BITS] + (p_q[0] ? {1'b0, mcand_q} : '0);
    p_step = {sum, p_q[BITS-1:0]} >> 1;
  end

  always_comb begin
    a_mag = a_i;
    b_mag = b_i;
`ifdef MUL32_SIGNED_EN
    if (sgn_i && a_i[BITS-1]) a_mag = -a_i;
    if (sgn_i && b_i[BITS-1]) b_mag = -b_i;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    p_d      = p_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
`ifdef MUL32_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mcand_d           = a_mag;
          p_d               = '0;
          p_d[BITS-1:0]     = b_mag;
          cnt_d             = '0;
          valid_d           = 1'b0;
          busy_d            = 1'b1;
          state_d           = S_RUN;
`ifdef MUL32_SIGNED_EN
          neg_d             = sgn_i & (a_i[BITS-1] ^ b_i[BITS-1]);
`endif
        end
      end
      S_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS-1)) begin
          cnt_d = '0;
`ifdef MUL32_SIGNED_EN
          state_d = S_FIX;
`else
          state_d  = S_DONE;
          result_d = p_step[2*BITS-1:0];
          busy_d   = 1'b0;
          done_d   = 1'b1;
          valid_d  = 1'b1;
`endif
        end
      end
`ifdef MUL32_SIGNED_EN
      // Unsigned operations also pass through FIX so latency does not depend on sgn_i.
      S_FIX: begin
        state_d  = S_DONE;
        result_d = neg_q ? -p_q[2*BITS-1:0] : p_q[2*BITS-1:0];
        busy_d   = 1'b0;
        done_d   = 1'b1;
        valid_d  = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      p_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef MUL32_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      p_q      <= p_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
`ifdef MUL32_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul32_seq_core.sv
// Randomised and directed bench for mul32_seq_core at BITS=32 and BITS=8, checked every cycle
// against a cycle-count/arithmetic model of the multiplier.
module tb_mul32_seq_core;

`ifdef MUL32_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int L = 33 + EXTRA;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic        sgn;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, valid32;
  logic [63:0] result32;
  logic        busy8, done8, valid8;
  logic [15:0] result8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul32_seq_core #(.BITS(32)) dut32 (
    .wb_clk_i(clk), .wb_rst_ni(rstN), .a_i(a32), .b_i(b32), .start_i(start),
`ifdef MUL32_SIGNED_EN
    .sgn_i(sgn),
`endif
    .busy_o(busy32), .done_o(done32), .valid_o(valid32), .result_o(result32)
  );

  mul32_seq_core #(.BITS(8)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rstN), .a_i(a8), .b_i(b8), .start_i(start),
`ifdef MUL32_SIGNED_EN
    .sgn_i(sgn),
`endif
    .busy_o(busy8), .done_o(done8), .valid_o(valid8), .result_o(result8)
  );

  // Behavioural model: index 0 is the 32-bit instance, index 1 the 8-bit one.
  int          bitsOf[2] = '{32, 8};
  bit          mRun[2], mBusy[2], mDone[2], mValid[2];
  int          mN[2];
  logic [63:0] mRes[2], mPend[2];

  function automatic logic [63:0] refProduct(logic [63:0] a, logic [63:0] b, bit s, int bits);
    logic [63:0] sa, sb, mask;
    sa = a << (64 - bits);
    sb = b << (64 - bits);
    if (s) begin
      sa = $signed(sa) >>> (64 - bits);
      sb = $signed(sb) >>> (64 - bits);
    end else begin
      sa = sa >> (64 - bits);
      sb = sb >> (64 - bits);
    end
    mask = (bits == 32) ? '1 : ((64'd1 << (2 * bits)) - 64'd1);
    return (sa * sb) & mask;
  endfunction

  task automatic modelStep(int i, logic [63:0] a, logic [63:0] b);
    int lat;
    lat = bitsOf[i] + 1 + EXTRA;
    if (!rstN) begin
      mRun[i] = 0; mBusy[i] = 0; mDone[i] = 0; mValid[i] = 0; mRes[i] = '0; mN[i] = 0;
    end else if (!mRun[i] && start) begin
      mRun[i] = 1; mN[i] = 1; mBusy[i] = 1; mDone[i] = 0; mValid[i] = 0;
      mPend[i] = refProduct(a, b, sgn, bitsOf[i]);
    end else if (mRun[i]) begin
      mN[i]++;
      if (mN[i] == lat) begin
        mRun[i] = 0; mBusy[i] = 0; mDone[i] = 1; mValid[i] = 1; mRes[i] = mPend[i];
      end
    end else begin
      mDone[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    modelStep(0, {32'b0, a32}, {32'b0, b32});
    modelStep(1, {56'b0, a8}, {56'b0, b8});
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("busy32", busy32, mBusy[0]);
    checkOutput("done32", done32, mDone[0]);
    checkOutput("valid32", valid32, mValid[0]);
    checkOutput("result32", result32, mRes[0]);
    checkOutput("busy8", busy8, mBusy[1]);
    checkOutput("done8", done8, mDone[1]);
    checkOutput("valid8", valid8, mValid[1]);
    checkOutput("result8", {48'b0, result8}, mRes[1]);
  end

  // Starts an operation in the current cycle (cycle 0) and walks to cycle L; optional
  // interfering start and reset cycles are counted from the accept edge.
  task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic [7:0] x8, logic [7:0] y8,
                               bit s, logic [63:0] exp, int intfAt, int rstAt);
    a32 = a; b32 = b; a8 = x8; b8 = y8; sgn = s; start = 1'b1;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (intfAt != 0 && c == intfAt) begin
        start = 1'b1; a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (intfAt != 0 && c == intfAt + 1) start = 1'b0;
      if (rstAt != 0 && c == rstAt) rstN = 1'b0;
      if (rstAt != 0 && c == rstAt + 1) begin
        rstN = 1'b1;
        checkOutput("rstBusy", busy32, 0);
        checkOutput("rstDone", done32, 0);
        checkOutput("rstValid", valid32, 0);
        checkOutput("rstResult", result32, 0);
      end
      if (c >= L - 1) checkOutput("doneCycle", done32, (c == L && rstAt == 0));
    end
    if (rstAt == 0) begin
      checkOutput("litResult", result32, exp);
      checkOutput("litValid", valid32, 1);
      checkOutput("litBusy", busy32, 0);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rstN = 1'b0; start = 1'b1; sgn = 1'b0;
    a32 = 32'h1234; b32 = 32'h5678; a8 = 8'h12; b8 = 8'h34;

    checkOutput("pinRef32", refProduct(64'hFFFFFFFF, 64'hFFFFFFFF, 0, 32), 64'hFFFFFFFE00000001);
    checkOutput("pinRef8", refProduct(64'hFF, 64'hFF, 0, 8), 64'hFE01);
    checkOutput("pinRefS8", refProduct(64'hFE, 64'h03, 1, 8), 64'hFFFA);

    repeat (2) @(negedge clk);
    rstN = 1'b1; start = 1'b0;
    checkOutput("resetBusy", busy32, 0);
    checkOutput("resetValid", valid32, 0);
    checkOutput("resetResult", result32, 0);
    repeat (3) @(negedge clk);
    checkOutput("idleAfterReset", valid32, 0);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 8'hFF, 0, 64'hFFFFFFFE00000001, 0, 0);
    applyStimulus(32'h12345678, 32'h0, 8'h5A, 8'h00, 0, 64'h0, 0, 0);
    applyStimulus(32'd3, 32'd5, 8'd3, 8'd5, 0, 64'hF, 0, 0);
    @(negedge clk);
    applyStimulus(32'd7, 32'd9, 8'd7, 8'd9, 0, 64'd63, 10, 0);
    @(negedge clk);
    applyStimulus(32'hDEADBEEF, 32'h01234567, 8'hDE, 8'h45, 0, 64'h0, 0, 15);
    repeat (40) @(negedge clk);
    applyStimulus(32'd5, 32'd6, 8'd5, 8'd6, 0, 64'd30, 0, 0);
`ifdef MUL32_SIGNED_EN
    applyStimulus(32'hFFFFFFFE, 32'd3, 8'hFE, 8'h03, 1, 64'hFFFFFFFFFFFFFFFA, 0, 0);
    applyStimulus(32'h80000000, 32'h80000000, 8'h80, 8'h80, 1, 64'h4000000000000000, 0, 0);
`endif

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      a32 = pickOperand();
      b32 = pickOperand();
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sgn = (EXTRA != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rstN = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    rstN = 1'b1; start = 1'b0;
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
